// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: fetch/decode/execute sequencer that drives an external ALU
// and register file from 9-bit instructions (op[8:5], fld[4:0]).
// Ports: clk, reset (sync, active-high), start; fetch handshake
//   instr_req/instr_addr/instr_valid/instr_data; ALU side alu_cmd,
//   ra_addr, rb_addr, opb_imm_sel, imm, alu_sc_i, alu_sc_o, alu_equal;
//   register write rf_we/rf_waddr; status busy/halted.
// Build option: ALU_CTRL_SEQ_CARRY_CHAIN_EN adds the carry flag register
//   feeding alu_sc_i; without it alu_sc_i is 0 and alu_sc_o is ignored.
module alu_ctrl_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       instr_req,
  output logic [9:0] instr_addr,
  input  logic       instr_valid,
  input  logic [8:0] instr_data,
  output logic [3:0] alu_cmd,
  output logic [2:0] ra_addr,
  output logic [2:0] rb_addr,
  output logic       opb_imm_sel,
  output logic [7:0] imm,
  output logic       alu_sc_i,
  input  logic       alu_sc_o,
  input  logic       alu_equal,
  output logic       rf_we,
  output logic [2:0] rf_waddr,
  output logic       busy,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT
  } state_t;

  localparam logic [3:0] OP_BNE  = 4'b1000;
  localparam logic [3:0] OP_BEQ  = 4'b1001;
  localparam logic [3:0] OP_HALT = 4'b1110;

  function automatic logic is_imm(input logic [3:0] op);
    return (op == 4'b0111) || (op == 4'b1010);
  endfunction

  function automatic logic is_cmp(input logic [3:0] op);
    return (op == OP_BNE) || (op == OP_BEQ) || (op == 4'b1101);
  endfunction

  function automatic logic writes(input logic [3:0] op);
    return !op[3] || (op == 4'b1010);
  endfunction

  state_t     state_q;
  logic [9:0] pc_q;
  logic [9:0] pc_d;
  logic [3:0] op_q;
  logic [4:0] fld_q;
  logic       eq_q;
  logic       req_q;
  logic [3:0] cmd_q;
  logic [2:0] ra_q;
  logic [2:0] rb_q;
  logic       sel_q;
  logic [7:0] imm_q;
  logic       we_q;
  logic [2:0] waddr_q;
  logic       busy_q;
  logic       halted_q;

  logic [3:0] dec_op;
  logic [2:0] dec_ra;
  logic [2:0] dec_rb;
  logic [2:0] dec_wa;
  logic       dec_sel;
  logic       taken;

  assign dec_op = instr_data[8:5];

  // Operand routing is decoded straight from the fetch bus so the
  // registered ALU controls are already valid in the DECODE cycle.
  always_comb begin
    dec_ra  = instr_data[4:2];
    dec_rb  = {1'b0, instr_data[1:0]};
    dec_wa  = instr_data[4:2];
    dec_sel = 1'b0;
    unique case (1'b1)
      is_imm(dec_op): begin
        dec_ra  = 3'd0;
        dec_wa  = 3'd0;
        dec_sel = 1'b1;
      end
      is_cmp(dec_op): begin
        dec_ra = 3'd0;
        dec_rb = 3'd1;
        dec_wa = 3'd0;
      end
      default: ;
    endcase
  end

  assign taken = ((op_q == OP_BEQ) && alu_equal)
              || ((op_q == OP_BNE) && !alu_equal);

  // 10-bit adds wrap modulo 1024 on their own.
  assign pc_d = taken ? pc_q + {{5{fld_q[4]}}, fld_q}
                      : pc_q + 10'd1;

`ifdef ALU_CTRL_SEQ_CARRY_CHAIN_EN
  logic carry_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      carry_q <= 1'b0;
    end else if (state_q == S_EXEC) begin
      if ((op_q == 4'b0000) || (op_q == 4'b0001)
          || (op_q == 4'b0010) || (op_q == 4'b0111))
        carry_q <= alu_sc_o;
    end
  end

  assign alu_sc_i = carry_q;
`else
  assign alu_sc_i = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= 10'd0;
      op_q     <= 4'd0;
      fld_q    <= 5'd0;
      eq_q     <= 1'b0;
      req_q    <= 1'b0;
      cmd_q    <= 4'b1111;
      ra_q     <= 3'd0;
      rb_q     <= 3'd0;
      sel_q    <= 1'b0;
      imm_q    <= 8'd0;
      we_q     <= 1'b0;
      waddr_q  <= 3'd0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_FETCH;
            pc_q    <= 10'd0;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_FETCH: begin
          if (instr_valid) begin
            state_q <= S_DECODE;
            req_q   <= 1'b0;
            op_q    <= dec_op;
            fld_q   <= instr_data[4:0];
            cmd_q   <= dec_op;
            ra_q    <= dec_ra;
            rb_q    <= dec_rb;
            sel_q   <= dec_sel;
            imm_q   <= {3'b000, instr_data[4:0]};
            waddr_q <= dec_wa;
          end
        end
        S_DECODE: begin
          state_q <= S_EXEC;
          we_q    <= writes(op_q);
        end
        S_EXEC: begin
          we_q <= 1'b0;
          if (is_cmp(op_q))
            eq_q <= alu_equal;
          if (op_q == OP_HALT) begin
            state_q  <= S_HALT;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            state_q <= S_FETCH;
            pc_q    <= pc_d;
            req_q   <= 1'b1;
          end
        end
        S_HALT: ;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The equal flag has no consumer on this interface; keep it for
  // future use without tripping unused-signal lint.
  logic unused_sig;
  assign unused_sig = ^{eq_q, alu_sc_o};

  assign instr_req   = req_q;
  assign instr_addr  = pc_q;
  assign alu_cmd     = cmd_q;
  assign ra_addr     = ra_q;
  assign rb_addr     = rb_q;
  assign opb_imm_sel = sel_q;
  assign imm         = imm_q;
  // Gate the strobe so an EXEC cycle hit by reset never writes back.
  assign rf_we       = we_q & ~reset;
  assign rf_waddr    = waddr_q;
  assign busy        = busy_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed scoreboard bench for alu_ctrl_seq.
// Expected fetch addresses and writebacks are queued as stimulus is driven.
module tb_alu_ctrl_seq;

  logic       clk;
  logic       reset;
  logic       start;
  logic       instr_req;
  logic [9:0] instr_addr;
  logic       instr_valid;
  logic [8:0] instr_data;
  logic [3:0] alu_cmd;
  logic [2:0] ra_addr;
  logic [2:0] rb_addr;
  logic       opb_imm_sel;
  logic [7:0] imm;
  logic       alu_sc_i;
  logic       alu_sc_o;
  logic       alu_equal;
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic       busy;
  logic       halted;

  alu_ctrl_seq dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .instr_req(instr_req),
    .instr_addr(instr_addr),
    .instr_valid(instr_valid),
    .instr_data(instr_data),
    .alu_cmd(alu_cmd),
    .ra_addr(ra_addr),
    .rb_addr(rb_addr),
    .opb_imm_sel(opb_imm_sel),
    .imm(imm),
    .alu_sc_i(alu_sc_i),
    .alu_sc_o(alu_sc_o),
    .alu_equal(alu_equal),
    .rf_we(rf_we),
    .rf_waddr(rf_waddr),
    .busy(busy),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       we;
    logic [2:0] wa;
  } wr_t;

  int         errors = 0;
  int         checks = 0;
  logic [9:0] pc_m;
  logic       carry_m;
  logic [9:0] exp_addr_q[$];
  wr_t        exp_wr_q[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".instr_req"}, 32'(instr_req), 0);
    chk({tag, ".instr_addr"}, 32'(instr_addr), 0);
    chk({tag, ".rf_we"}, 32'(rf_we), 0);
    chk({tag, ".alu_cmd"}, 32'(alu_cmd), 32'hF);
    chk({tag, ".ra"}, 32'(ra_addr), 0);
    chk({tag, ".rb"}, 32'(rb_addr), 0);
    chk({tag, ".waddr"}, 32'(rf_waddr), 0);
    chk({tag, ".imm"}, 32'(imm), 0);
    chk({tag, ".opb_sel"}, 32'(opb_imm_sel), 0);
    chk({tag, ".alu_sc_i"}, 32'(alu_sc_i), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".halted"}, 32'(halted), 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    pc_m = 10'd0;
    exp_addr_q.push_back(10'd0);
  endtask

  task automatic run_instr(input logic [8:0] ins, input int waitn,
                           input logic eq, input logic sco,
                           input logic abort);
    logic [3:0] op;
    logic [4:0] f;
    logic [9:0] ea;
    logic       isimm;
    logic       isbr;
    logic       exp_sci;
    wr_t        ew;
    op = ins[8:5];
    f  = ins[4:0];
    isimm = (op == 4'd7) || (op == 4'd10);
    isbr  = (op == 4'd8) || (op == 4'd9) || (op == 4'd13);
    ea = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 10'h3FF;
    for (int i = 0; i <= waitn; i++) begin
      chk("fetch.instr_req", 32'(instr_req), 1);
      chk("fetch.instr_addr", 32'(instr_addr), 32'(ea));
      if (i == 0) chk("fetch.rf_we", 32'(rf_we), 0);
      if (i == waitn) begin
        instr_valid = 1'b1;
        instr_data  = ins;
        ew.we = !op[3] || (op == 4'd10);
        ew.wa = isimm ? 3'd0 : f[4:2];
        exp_wr_q.push_back(ew);
      end
      step();
    end
    instr_valid = 1'b0;
    instr_data  = 9'($urandom);
`ifdef ALU_CTRL_SEQ_CARRY_CHAIN_EN
    exp_sci = carry_m;
`else
    exp_sci = 1'b0;
`endif
    chk("dec.instr_req", 32'(instr_req), 0);
    chk("dec.busy", 32'(busy), 1);
    chk("dec.alu_cmd", 32'(alu_cmd), 32'(op));
    chk("dec.ra", 32'(ra_addr), (isimm || isbr) ? 0 : 32'(f[4:2]));
    if (!isimm)
      chk("dec.rb", 32'(rb_addr), isbr ? 1 : 32'(f[1:0]));
    chk("dec.opb_sel", 32'(opb_imm_sel), 32'(isimm));
    if (isimm) chk("dec.imm", 32'(imm), 32'(f));
    chk("dec.alu_sc_i", 32'(alu_sc_i), 32'(exp_sci));
    alu_equal = eq;
    alu_sc_o  = sco;
    step();
    ew = (exp_wr_q.size() > 0) ? exp_wr_q.pop_front() : '0;
    if (abort) begin
      reset = 1'b1;
      #1;
      chk("abort.rf_we", 32'(rf_we), 0);
      step();
      reset = 1'b0;
      chk("abort.busy", 32'(busy), 0);
      chk("abort.instr_req", 32'(instr_req), 0);
      chk("abort.alu_sc_i", 32'(alu_sc_i), 0);
      chk("abort.instr_addr", 32'(instr_addr), 0);
      pc_m = 10'd0;
      carry_m = 1'b0;
      exp_addr_q.delete();
      exp_wr_q.delete();
      return;
    end
    chk("exec.rf_we", 32'(rf_we), 32'(ew.we));
    if (ew.we) chk("exec.waddr", 32'(rf_waddr), 32'(ew.wa));
    chk("exec.alu_cmd", 32'(alu_cmd), 32'(op));
`ifdef ALU_CTRL_SEQ_CARRY_CHAIN_EN
    if (op == 4'd0 || op == 4'd1 || op == 4'd2 || op == 4'd7)
      carry_m = sco;
`endif
    if ((op == 4'd9 && eq) || (op == 4'd8 && !eq))
      pc_m = pc_m + {{5{f[4]}}, f};
    else if (op != 4'd14)
      pc_m = pc_m + 10'd1;
    step();
    if (op == 4'd14) begin
      chk("halt.halted", 32'(halted), 1);
      chk("halt.busy", 32'(busy), 0);
      chk("halt.instr_req", 32'(instr_req), 0);
    end else begin
      exp_addr_q.push_back(pc_m);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    instr_valid = 1'b0;
    instr_data = 9'd0;
    alu_sc_o = 1'b0;
    alu_equal = 1'b0;
    pc_m = 10'd0;
    carry_m = 1'b0;
    step();
    step();
    chk_reset_vals("rst");
    reset = 1'b0;

    instr_valid = 1'b1;
    instr_data = 9'h0AB;
    step();
    instr_valid = 1'b0;
    chk("idle_valid.busy", 32'(busy), 0);
    chk("idle_valid.instr_req", 32'(instr_req), 0);
    step();
    chk("idle_valid.busy2", 32'(busy), 0);

    do_start();
    run_instr(9'b0000_00101, 2, 1'b0, 1'b0, 1'b0);
    run_instr(9'b0001_01010, 0, 1'b0, 1'b1, 1'b0);
    run_instr(9'b0111_11111, 1, 1'b0, 1'b1, 1'b0);
    run_instr(9'b0000_00000, 0, 1'b0, 1'b0, 1'b0);
    run_instr(9'b1011_00000, 0, 1'b0, 1'b0, 1'b0);
    run_instr(9'b1001_11110, 0, 1'b1, 1'b0, 1'b0);
    run_instr(9'b1001_11110, 1, 1'b0, 1'b0, 1'b0);
    run_instr(9'b1000_00011, 0, 1'b1, 1'b0, 1'b0);
    run_instr(9'b1101_00000, 0, 1'b1, 1'b0, 1'b0);
    run_instr(9'b0000_10011, 0, 1'b0, 1'b1, 1'b1);

    do_start();
    run_instr(9'b1000_11111, 0, 1'b0, 1'b0, 1'b0);
    run_instr(9'b1111_00000, 0, 1'b0, 1'b1, 1'b0);
    run_instr(9'b1100_00000, 0, 1'b0, 1'b0, 1'b0);
    run_instr(9'b1010_00101, 0, 1'b0, 1'b0, 1'b0);
    run_instr(9'b0010_10011, 0, 1'b0, 1'b1, 1'b1);

    do_start();
    run_instr(9'b1110_00000, 0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    chk("halt_start.halted", 32'(halted), 1);
    chk("halt_start.instr_req", 32'(instr_req), 0);
    chk("halt_start.busy", 32'(busy), 0);
    reset = 1'b1;
    step();
    chk_reset_vals("halt_rst");
    reset = 1'b0;
    step();
    chk("post_rst.halted", 32'(halted), 0);
    chk("post_rst.busy", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 start  input  1  begin execution at instr_addr 0; sampled only in IDLE.
REQ-004 instr_req  output  1  fetch request; held high until accepted.
REQ-005 instr_addr  output  10  fetch address (= PC).
REQ-006 instr_valid  input  1  instr_data valid; accepted only while instr_req high.
REQ-007 instr_data  input  9  instruction: op[8:5], fld[4:0].
REQ-008 alu_cmd  output  4  ALU operation code.
REQ-009 ra_addr, rb_addr  output  3 each  register-file read ports driving ALU inA/inB.
REQ-010 opb_imm_sel  output  1  1 = ALU inB is imm, 0 = register rb.
REQ-011 imm  output  8  zero-extended fld[4:0].
REQ-012 alu_sc_i  output  1  carry into ALU.
REQ-013 alu_sc_o, alu_equal  input  1 each  ALU carry-out and equality result.
REQ-014 rf_we  output  1  one-cycle register write strobe; rf_waddr  output  3  write address.
REQ-015 busy, halted  output  1 each  status.

Function
REQ-016 FSM states IDLE, FETCH, DECODE, EXEC, HALT; IDLE->FETCH on start (PC=0); FETCH->DECODE on instr_valid; DECODE->EXEC always; EXEC->FETCH, or EXEC->HALT for op 1110; HALT stays until reset.
REQ-017 FETCH: instr_req=1, instr_addr=PC stable; instr_data captured on the cycle instr_valid=1; no timeout, wait is unbounded.
REQ-018 DECODE: latch op/fld; ALU-facing outputs (alu_cmd, ra/rb_addr, opb_imm_sel, imm, alu_sc_i) valid from DECODE through the end of EXEC.
REQ-019 Register ops (0000-0110, 1111): ra=fld[4:2], rb={0,fld[1:0]}, dest=ra, opb_imm_sel=0.
REQ-020 Immediate ops (0111, 1010): ra=0, dest=0, opb_imm_sel=1, imm={3'b0,fld}.
REQ-021 Branch/compare ops (1000 bne, 1001 beq, 1101 cmp): ra=0, rb=1, opb_imm_sel=0, no write.
REQ-022 rf_we=1 in EXEC only for ops 0000-0111 and 1010; ops 1111, 1000, 1001, 1101, 1011, 1100, 1110 never write.
REQ-023 Carry flag updated from alu_sc_o at end of EXEC for ops 0000, 0001, 0010, 0111 only; alu_sc_i = carry flag.
REQ-024 Equal flag updated from alu_equal at end of EXEC for ops 1000, 1001, 1101.
REQ-025 Next PC: beq with alu_equal=1 or bne with alu_equal=0 -> PC + sign-extended fld (modulo 1024); else PC+1, 1023 wraps to 0.
REQ-026 Ops 1011, 1100 behave as no-op (PC+1); 1110 = halt, PC unchanged.
REQ-027 busy=1 in FETCH/DECODE/EXEC; halted=1 only in HALT.
REQ-028 instr_valid outside FETCH ignored; start outside IDLE ignored.
REQ-029 Latency per instruction = fetch wait + 3 cycles (FETCH accept, DECODE, EXEC).

Reset
REQ-030 reset dominates all inputs, including mid-fetch and EXEC; next state IDLE.
REQ-031 Reset values: PC=0, carry=0, equal flag=0, instr_req=0, rf_we=0, alu_cmd=4'b1111, ra/rb/rf_waddr=0, imm=0, opb_imm_sel=0, busy=0, halted=0.
REQ-032 rf_we SHALL NOT assert in the cycle reset is high; an instruction in flight is abandoned without writeback.

Configuration
REQ-033 Macro ALU_CTRL_SEQ_CARRY_CHAIN_EN: defined -> carry flag register per REQ-023; undefined -> no carry register, alu_sc_i constant 0, alu_sc_o ignored.

Verification
REQ-034 reset, start, instr 0000_00101 (add r1,r1), valid after 2-cycle wait -> instr_req held 3 cycles, rf_we one cycle with rf_waddr=1, next instr_addr=1.
REQ-035 0111_11111 with carry=1 (macro defined) -> imm=8'h1F, opb_imm_sel=1, alu_sc_i=1, rf_waddr=0; alu_sc_o=1 -> carry stays 1; macro undefined -> alu_sc_i=0.
REQ-036 PC=5, 1001_11110 (beq, -2) with alu_equal=1 -> next instr_addr=3; alu_equal=0 -> 6; bne at PC=0 offset -1 with alu_equal=0 -> 1023.
REQ-037 PC=1023 executing 1111_00000 -> rf_we stays 0, next instr_addr=0.
REQ-038 1110_00000 -> halted=1, busy=0, instr_req=0, start ignored; reset -> IDLE, all outputs at REQ-031 values.
REQ-039 reset asserted in EXEC of an add -> rf_we=0 that cycle, carry=0, state IDLE next cycle; instr_valid pulse in IDLE -> no state change.
